fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the in-order integer pipeline; the next generation of the EX-stage forwarding mux-select logic. It tracks every in-flight register writer in an internal shadow pipeline (EX through the last forwarding stage) and resolves, one cycle early in ID, which stage each EX source operand must be forwarded from. It also generates load-use stall requests with a configurable load latency. It sits beside the ID/EX pipeline register and drives the EX-stage operand muxes from registered selects.

---
 rtl/fwd_scoreboard_pkg.sv | 27 ++
 rtl/fwd_scoreboard_if.sv | 30 +++
 rtl/fwd_scoreboard_match.sv | 38 +++
 rtl/fwd_scoreboard.sv | 73 +++++++
 tb/tb_fwd_scoreboard.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types and helpers for the forwarding scoreboard: shadow-pipe entry
// layout, the register-file select constant and stage-to-select mapping.
package fwd_pkg;

    // Entries store rd zero-extended to this width so the struct is
    // independent of the REG_AW chosen per instance.
    localparam int REG_AW_MAX = 8;

    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  is_load;
        logic [REG_AW_MAX-1:0] rd;
    } sb_entry_t;

    // Slot i seen from ID becomes stage i+1 once the consumer reaches EX.
    function automatic int stage_sel(input int slot);
        return slot + 1;
    endfunction

    function automatic logic is_producer(input sb_entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID-side handshake between the decode stage and the forwarding scoreboard.
interface fwd_scoreboard_if #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic                             hold;
    logic                             flush;
    logic                             id_valid;
    logic                             id_regwrite;
    logic                             id_is_load;
    logic [REG_AW-1:0]                id_rd;
    logic [NUM_SRC-1:0][REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]               id_rs_used;
    logic                             id_stall;
    logic [NUM_SRC-1:0][SEL_W-1:0]    ex_fwd_sel;

    modport master (
        output hold, flush, id_valid, id_regwrite, id_is_load, id_rd, id_rs, id_rs_used,
        input  id_stall, ex_fwd_sel
    );

    modport slave (
        input  hold, flush, id_valid, id_regwrite, id_is_load, id_rd, id_rs, id_rs_used,
        output id_stall, ex_fwd_sel
    );

endinterface

// File: rtl/fwd_scoreboard_match.sv
// Per-source youngest-match priority encoder over the in-flight writers.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  sb_entry_t         slots [NUM_STAGES],
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    output logic [SEL_W-1:0]  sel,
    output logic              not_ready
);

    logic found;

    // The first (youngest) match decides; an older writer is never used
    // even when the youngest one is a load that is not yet forwardable.
    always_comb begin
        sel       = SEL_W'(FWD_SEL_RF);
        not_ready = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (!found && rs_used && is_producer(slots[i]) &&
                (slots[i].rd == REG_AW_MAX'(rs))) begin
                found = 1'b1;
                if (slots[i].is_load && (stage_sel(i) < LOAD_LAT)) begin
                    not_ready = 1'b1;
                end else begin
                    sel = SEL_W'(stage_sel(i));
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: shadow pipe of in-flight writers, registered EX
// operand selects and combinational load-use stall.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 2
) (
    input logic              clk,
    input logic              rst,
    fwd_scoreboard_if.slave  bus
);

    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    sb_entry_t                     slots     [NUM_STAGES+1];
    sb_entry_t                     match_view[NUM_STAGES];
    logic [NUM_SRC-1:0][SEL_W-1:0] next_sel;
    logic [NUM_SRC-1:0]            not_ready;
    logic                          issue;
    sb_entry_t                     id_entry;

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            match_view[i] = slots[i];
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_match #(
            .NUM_STAGES(NUM_STAGES),
            .REG_AW    (REG_AW),
            .LOAD_LAT  (LOAD_LAT),
            .SEL_W     (SEL_W)
        ) u_match (
            .slots    (match_view),
            .rs       (bus.id_rs[s]),
            .rs_used  (bus.id_rs_used[s]),
            .sel      (next_sel[s]),
            .not_ready(not_ready[s])
        );
    end

    assign bus.id_stall = bus.id_valid && (|not_ready);
    assign issue        = bus.id_valid && !bus.id_stall && !bus.flush;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = 1'b1;
        id_entry.regwrite = bus.id_regwrite;
        id_entry.is_load  = bus.id_is_load;
        id_entry.rd       = REG_AW_MAX'(bus.id_rd);
    end

    // ID -> EX boundary plus the shadow stages behind EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= NUM_STAGES; k++) begin
                slots[k] <= '0;
            end
            bus.ex_fwd_sel <= '0;
        end else if (!bus.hold) begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                slots[k] <= slots[k-1];
            end
            slots[0]       <= issue ? id_entry : '0;
            bus.ex_fwd_sel <= issue ? next_sel : '0;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default build plus a 3-stage/LOAD_LAT=3 build.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.NUM_SRC(2), .NUM_STAGES(2), .REG_AW(5)) a ();
    fwd_scoreboard_if #(.NUM_SRC(2), .NUM_STAGES(3), .REG_AW(5)) b ();

    fwd_scoreboard #(.NUM_SRC(2), .NUM_STAGES(2), .REG_AW(5), .LOAD_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(a)
    );

    fwd_scoreboard #(.NUM_SRC(2), .NUM_STAGES(3), .REG_AW(5), .LOAD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(b)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic rw, input logic ld, input int rd,
                           input int rs0, input int rs1, input logic [1:0] used);
        a.id_valid    = v;
        a.id_regwrite = rw;
        a.id_is_load  = ld;
        a.id_rd       = 5'(rd);
        a.id_rs[0]    = 5'(rs0);
        a.id_rs[1]    = 5'(rs1);
        a.id_rs_used  = used;
    endtask

    task automatic drive_b(input logic v, input logic rw, input logic ld, input int rd,
                           input int rs0, input int rs1, input logic [1:0] used);
        b.id_valid    = v;
        b.id_regwrite = rw;
        b.id_is_load  = ld;
        b.id_rd       = 5'(rd);
        b.id_rs[0]    = 5'(rs0);
        b.id_rs[1]    = 5'(rs1);
        b.id_rs_used  = used;
    endtask

    task automatic drain_a();
        drive_a(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00);
        repeat (3) tick();
    endtask

    initial begin
        a.hold = 1'b0; a.flush = 1'b0;
        b.hold = 1'b0; b.flush = 1'b0;
        drive_a(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00);
        drive_b(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00);

        // Reset state
        repeat (2) tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 5, 7, 2'b11);
        #1;
        check_val("rst_sel0", int'(a.ex_fwd_sel[0]), 0);
        check_val("rst_sel1", int'(a.ex_fwd_sel[1]), 0);
        check_val("rst_stall", int'(a.id_stall), 0);
        rst = 1'b0;
        drain_a();

        // Back-to-back ALU forward
        drive_a(1'b1, 1'b1, 1'b0, 5, 1, 2, 2'b11);
        tick();
        drive_a(1'b1, 1'b1, 1'b0, 6, 5, 3, 2'b11);
        #1;
        check_val("b2b_stall", int'(a.id_stall), 0);
        tick();
        check_val("b2b_sel0", int'(a.ex_fwd_sel[0]), 1);
        check_val("b2b_sel1", int'(a.ex_fwd_sel[1]), 0);
        drain_a();
        check_val("drain_sel0", int'(a.ex_fwd_sel[0]), 0);

        // Two writers to x5: the youngest wins
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 5, 0, 2'b01);
        tick();
        check_val("prio_sel0", int'(a.ex_fwd_sel[0]), 1);
        drain_a();

        // Single writer two ahead -> stage 2
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        tick();
        drive_a(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 0, 5, 2'b11);
        tick();
        check_val("dist2_sel1", int'(a.ex_fwd_sel[1]), 2);
        check_val("dist2_sel0", int'(a.ex_fwd_sel[0]), 0);
        drain_a();

        // Writer three ahead has left the forwarding window
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        tick();
        drive_a(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00);
        repeat (2) tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 5, 0, 2'b01);
        tick();
        check_val("dist3_sel0", int'(a.ex_fwd_sel[0]), 0);
        drain_a();

        // Load-use, default LOAD_LAT=2
        drive_a(1'b1, 1'b1, 1'b1, 7, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 7, 0, 2'b01);
        #1;
        check_val("lu_stall1", int'(a.id_stall), 1);
        tick();
        check_val("lu_bubble_sel0", int'(a.ex_fwd_sel[0]), 0);
        check_val("lu_stall2", int'(a.id_stall), 0);
        tick();
        check_val("lu_sel0", int'(a.ex_fwd_sel[0]), 2);
        drain_a();

        // x0 writer is never forwarded
        drive_a(1'b1, 1'b1, 1'b0, 0, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 0, 0, 2'b11);
        tick();
        check_val("x0_sel0", int'(a.ex_fwd_sel[0]), 0);
        drain_a();

        // Unused source matching a load: no stall, no forward
        drive_a(1'b1, 1'b1, 1'b1, 9, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b0, 1'b0, 0, 9, 1, 2'b10);
        #1;
        check_val("unused_stall", int'(a.id_stall), 0);
        tick();
        check_val("unused_sel0", int'(a.ex_fwd_sel[0]), 0);
        drain_a();

        // Hold freezes slots and selects
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b1, 1'b0, 6, 5, 0, 2'b01);
        tick();
        a.hold = 1'b1;
        a.flush = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("hold_sel0", int'(a.ex_fwd_sel[0]), 1);
        end
        a.hold = 1'b0;
        a.flush = 1'b0;
        drive_a(1'b1, 1'b0, 1'b0, 0, 6, 5, 2'b11);
        tick();
        check_val("resume_sel0", int'(a.ex_fwd_sel[0]), 1);
        check_val("resume_sel1", int'(a.ex_fwd_sel[1]), 2);
        drain_a();

        // Flush kills the instruction entering EX
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        a.flush = 1'b1;
        tick();
        a.flush = 1'b0;
        check_val("flush_sel0", int'(a.ex_fwd_sel[0]), 0);
        drive_a(1'b1, 1'b0, 1'b0, 0, 5, 0, 2'b01);
        tick();
        check_val("flush_kill_sel0", int'(a.ex_fwd_sel[0]), 0);
        drain_a();

        // Reset during a load-use stall
        drive_a(1'b1, 1'b1, 1'b0, 5, 0, 0, 2'b00);
        tick();
        drive_a(1'b1, 1'b1, 1'b1, 7, 5, 0, 2'b01);
        tick();
        check_val("pre_rst_sel0", int'(a.ex_fwd_sel[0]), 1);
        drive_a(1'b1, 1'b0, 1'b0, 0, 7, 0, 2'b01);
        #1;
        check_val("pre_rst_stall", int'(a.id_stall), 1);
        rst = 1'b1;
        #1;
        check_val("rst_mid_sel0", int'(a.ex_fwd_sel[0]), 0);
        check_val("rst_mid_stall", int'(a.id_stall), 0);
        tick();
        rst = 1'b0;
        #1;
        check_val("post_rst_stall", int'(a.id_stall), 0);
        tick();
        check_val("post_rst_sel0", int'(a.ex_fwd_sel[0]), 0);
        drain_a();

        // LOAD_LAT=3, NUM_STAGES=3: two stall cycles, select 3
        drive_b(1'b1, 1'b1, 1'b1, 7, 0, 0, 2'b00);
        tick();
        drive_b(1'b1, 1'b0, 1'b0, 0, 7, 0, 2'b01);
        #1;
        check_val("l3_stall1", int'(b.id_stall), 1);
        tick();
        check_val("l3_stall2", int'(b.id_stall), 1);
        check_val("l3_bubble_sel0", int'(b.ex_fwd_sel[0]), 0);
        tick();
        check_val("l3_stall3", int'(b.id_stall), 0);
        tick();
        check_val("l3_sel0", int'(b.ex_fwd_sel[0]), 3);
        drive_b(1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
